// File: rtl/serial_add_sub_pkg.sv
// Shared constants for the bit-serial adder/subtractor.
// State encodings are fixed so other blocks can decode them.
package serial_add_sub_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_e;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Full-adder cell built from two half adders and an OR.
module FULL_ADDER (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic S,
   output logic CO
);

   logic s0;
   logic c0;
   logic c1;

   HALF_ADDER u_ha0 (
      .A (A),
      .B (B),
      .S (s0),
      .C (c0)
   );

   HALF_ADDER u_ha1 (
      .A (s0),
      .B (CI),
      .S (S),
      .C (c1)
   );

   assign CO = c0 | c1;

endmodule

// File: rtl/serial_add_sub_half_adder.sv
// Single-bit half adder primitive.
module HALF_ADDER (
   input  logic A,
   input  logic B,
   output logic S,
   output logic C
);

   assign S = A ^ B;
   assign C = A & B;

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/sub: one full-adder cell reused LSB-first,
// one bit per clock, with a start/busy/done handshake.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic                  SnA,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   output logic [DATA_WIDTH-1:0] Y,
   output logic                  CO,
   output logic                  OVF,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   state_e                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   opa_q, opa_d;
   logic [DATA_WIDTH-1:0]   opb_q, opb_d;
   logic [DATA_WIDTH-1:0]   res_q, res_d;
   logic [DATA_WIDTH-1:0]   y_q, y_d;
   logic                    carry_q, carry_d;
   logic                    co_q, co_d;
   logic                    ovf_q, ovf_d;
   logic                    fa_s;
   logic                    fa_co;

   FULL_ADDER u_fa (
      .A  (opa_q[0]),
      .B  (opb_q[0]),
      .CI (carry_q),
      .S  (fa_s),
      .CO (fa_co)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      y_d     = y_q;
      carry_d = carry_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (START) begin
               state_d = RUN;
               opa_d   = A;
               opb_d   = SnA ? ~B : B;
               carry_d = SnA;
               cnt_d   = '0;
            end
         end
         RUN: begin
            res_d   = {fa_s, res_q[DATA_WIDTH-1:1]};
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            carry_d = fa_co;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            // carry_q here is the carry into the MSB
            if (cnt_q == LAST) begin
               y_d     = {fa_s, res_q[DATA_WIDTH-1:1]};
               co_d    = fa_co;
               ovf_d   = carry_q ^ fa_co;
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
      end
   end

   assign Y    = y_q;
   assign CO   = co_q;
   assign OVF  = ovf_q;
   assign BUSY = (state_q == RUN);
   assign DONE = (state_q == FIN);

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed and random
// operations against a plain-arithmetic reference.
module tb_serial_add_sub;

   localparam int W = 32;
   localparam longint MAXS = 64'sh0000_0000_7FFF_FFFF;
   localparam longint MINS = -64'sh0000_0000_8000_0000;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START;
   logic         SnA;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] Y;
   logic         CO;
   logic         OVF;
   logic         BUSY;
   logic         DONE;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   serial_add_sub #(
      .DATA_WIDTH (W),
      .CNT_WIDTH  (6)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .SnA   (SnA),
      .A     (A),
      .B     (B),
      .Y     (Y),
      .CO    (CO),
      .OVF   (OVF),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; drives START immediately.
   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic sna, input int glitch,
                     input string tag);
      logic [W-1:0] ey;
      logic [W-1:0] prev_y;
      logic         prev_co;
      logic         prev_ovf;
      logic         eco;
      logic         eovf;
      longint       r;
      int           cyc;
      int           busy_n;
      ey = sna ? a - b : a + b;
      if (sna) eco = (a >= b);
      else eco = ((longint'(a) + longint'(b)) > longint'(32'hFFFF_FFFF));
      if (sna) r = longint'(signed'(a)) - longint'(signed'(b));
      else r = longint'(signed'(a)) + longint'(signed'(b));
      eovf = (r > MAXS) || (r < MINS);
      prev_y   = Y;
      prev_co  = CO;
      prev_ovf = OVF;
      START = 1'b1;
      A = a;
      B = b;
      SnA = sna;
      @(posedge CLK);
      #1;
      START = 1'b0;
      A = $urandom;
      B = $urandom;
      SnA = 1'($urandom);
      @(negedge CLK);
      cyc = 1;
      busy_n = BUSY ? 1 : 0;
      chk({tag, " y_hold"}, Y, prev_y);
      chk({tag, " co_hold"}, W'(CO), W'(prev_co));
      chk({tag, " ovf_hold"}, W'(OVF), W'(prev_ovf));
      while (!DONE && cyc < 100) begin
         if (cyc == glitch) begin
            START = 1'b1;
            A = 100;
            B = 100;
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
         cyc++;
         if (BUSY) busy_n++;
      end
      START = 1'b0;
      chk({tag, " latency"}, W'(cyc), W'(W + 1));
      chk({tag, " busy_cycles"}, W'(busy_n), W'(W));
      chk({tag, " y"}, Y, ey);
      chk({tag, " co"}, W'(CO), W'(eco));
      chk({tag, " ovf"}, W'(OVF), W'(eovf));
      @(negedge CLK);
      chk({tag, " done_pulse"}, W'(DONE), '0);
      chk({tag, " y_stable"}, Y, ey);
   endtask

   initial begin
      int done_seen;
      RST = 1'b1;
      START = 1'b0;
      SnA = 1'b0;
      A = '0;
      B = '0;
      #2;
      chk("reset y", Y, '0);
      chk("reset flags", W'({CO, OVF, BUSY, DONE}), '0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      op(32'd5, 32'd3, 1'b0, 0, "add5_3");
      op(32'h7FFF_FFFF, 32'd1, 1'b0, 0, "ovf_add");
      op(32'd5, 32'd7, 1'b1, 0, "sub5_7");
      op(32'd7, 32'd5, 1'b1, 0, "sub7_5");
      op(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "wrap");
      op(32'd1, 32'd1, 1'b0, 10, "start_ignored");
      op(32'd100, 32'd1, 1'b0, 0, "back2back");

      // Abort mid-operation: outputs clear at once, no DONE follows.
      START = 1'b1;
      A = 32'h1234_5678;
      B = 32'h1111_1111;
      SnA = 1'b0;
      @(posedge CLK);
      #1;
      START = 1'b0;
      repeat (15) @(negedge CLK);
      #1;
      RST = 1'b1;
      #1;
      chk("rst_mid y", Y, '0);
      chk("rst_mid flags", W'({CO, OVF, BUSY, DONE}), '0);
      @(negedge CLK);
      RST = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (DONE) done_seen++;
      end
      chk("rst_mid no_done", W'(done_seen), '0);
      op(32'h0000_1000, 32'h0000_0234, 1'b0, 0, "after_rst");

      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = (i % 4 == 0) ? ra : $urandom;
         op(ra, rb, 1'($urandom), 0, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
